// File: rtl/cpu_memarb_pkg.sv
// Shared types for the CPU memory arbiter: FSM states and arbitration mode codes.
package cpu_memarb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/cpu_memarb_pick.sv
// Combinational winner selection: lowest set index (fixed) or first set index after
// 'last' with wrap-around (round robin).
module cpu_memarb_pick
    import cpu_memarb_pkg::*;
#(
    parameter  int NCH  = 2,
    parameter  int MODE = ARB_FIXED,
    localparam int GW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] eligible,
    input  logic [GW-1:0]  last,
    output logic           valid,
    output logic [GW-1:0]  index
);

    logic [GW:0]     start;
    logic [NCH-1:0]  rot;
    logic [GW-1:0]   rr_idx;
    logic [GW-1:0]   fx_idx;

    function automatic logic [GW-1:0] wrap_idx(input int s);
        return GW'((s >= NCH) ? s - NCH : s);
    endfunction

    // Rotating a doubled copy puts channel last+1 at bit 0, so the search is a plain priority scan.
    always_comb begin
        start = {1'b0, last} + 1'b1;
        if (start >= (GW+1)'(NCH)) begin
            start = '0;
        end
        rot    = NCH'({eligible, eligible} >> start);
        rr_idx = '0;
        fx_idx = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                rr_idx = wrap_idx(int'(start) + j);
            end
            if (eligible[j]) begin
                fx_idx = GW'(j);
            end
        end
        valid = |eligible;
        index = (MODE == ARB_RR) ? rr_idx : fx_idx;
    end

endmodule

// File: rtl/cpu_memarb.sv
// Registered N-channel arbiter onto one external memory bus with wait-state
// handshake and optional timeout abort.
module cpu_memarb
    import cpu_memarb_pkg::*;
#(
    parameter  int NCH      = 2,
    parameter  int AW       = 24,
    parameter  int DW       = 16,
    parameter  int MODE     = ARB_FIXED,
    parameter  int MAX_WAIT = 0,
    localparam int GW       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int BW       = DW / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req_i,
    input  logic [NCH-1:0]    we_i,
    input  logic [NCH*AW-1:0] addr_i,
    input  logic [NCH*DW-1:0] wdata_i,
    input  logic [NCH*BW-1:0] be_i,
    output logic [NCH-1:0]    ack_o,
    output logic              err_o,
    output logic [DW-1:0]     rdata_o,
    output logic [GW-1:0]     grant_o,
    output logic              busy_o,
    output logic [AW-1:0]     addr_o,
    output logic              re_o,
    output logic              we_o,
    output logic [BW-1:0]     be_o,
    output logic [DW-1:0]     data_o,
    output logic              data_oe_o,
    input  logic [DW-1:0]     data_i,
    input  logic              needWait_i
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    state_t          state;
    state_t          state_nx;
    logic [GW-1:0]   last;
    logic [CW-1:0]   wait_cnt;
    logic [NCH-1:0]  eligible;
    logic            pick_vld;
    logic [GW-1:0]   pick_idx;
    logic            timeout;
    logic            do_grant;
    logic            do_done;
    logic            do_abort;

    // The ack mask keeps a requester that is still dropping req_i from winning again.
    assign eligible  = req_i & ~ack_o;
    assign timeout   = (MAX_WAIT != 0) && needWait_i && (int'(wait_cnt) == MAX_WAIT - 1);
    assign data_oe_o = we_o;

    cpu_memarb_pick #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_pick (
        .eligible (eligible),
        .last     (last),
        .valid    (pick_vld),
        .index    (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = ACCESS;
            ACCESS:  if (!needWait_i || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        do_grant = 1'b0;
        do_done  = 1'b0;
        do_abort = 1'b0;
        case (state)
            IDLE:   do_grant = pick_vld;
            ACCESS: begin
                do_done  = !needWait_i;
                do_abort = timeout;
            end
            default: ;
        endcase
    end

    // Command is latched at grant so requester-side changes during ACCESS are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_o    <= '0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
            grant_o  <= '0;
            busy_o   <= 1'b0;
            addr_o   <= '0;
            re_o     <= 1'b0;
            we_o     <= 1'b0;
            be_o     <= '0;
            data_o   <= '0;
            last     <= GW'(NCH - 1);
            wait_cnt <= '0;
        end else begin
            ack_o <= '0;
            err_o <= 1'b0;
            if (do_grant) begin
                grant_o  <= pick_idx;
                last     <= pick_idx;
                busy_o   <= 1'b1;
                re_o     <= ~we_i[pick_idx];
                we_o     <= we_i[pick_idx];
                addr_o   <= addr_i[pick_idx*AW +: AW];
                data_o   <= wdata_i[pick_idx*DW +: DW];
                be_o     <= be_i[pick_idx*BW +: BW];
                wait_cnt <= '0;
            end else if (do_done || do_abort) begin
                ack_o[grant_o] <= 1'b1;
                err_o          <= do_abort;
                if (do_done && re_o) begin
                    rdata_o <= data_i;
                end
                re_o   <= 1'b0;
                we_o   <= 1'b0;
                be_o   <= '0;
                busy_o <= 1'b0;
            end else if (state == ACCESS) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

endmodule
